// File: rtl/k2_pkg.sv
// k2_pkg: shared definitions for the K2 fetch/execute engine.
//   - instruction field positions
//   - destination selector and FSM state encodings
//   - small decode helpers used by k2_core
package k2_pkg;

  // Instruction field positions inside the 8-bit instruction word
  localparam int J_BIT = 7;
  localparam int C_BIT = 6;
  localparam int D_MSB = 5;
  localparam int D_LSB = 4;
  localparam int S_BIT = 3;
  localparam int SUB_BIT = 2;

  typedef enum logic [1:0] {
    DST_RA   = 2'b00,
    DST_RB   = 2'b01,
    DST_RO   = 2'b10,
    DST_NONE = 2'b11
  } dest_t;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  // Destination field of an instruction word
  function automatic dest_t inst_dest(input logic [7:0] ir);
    return dest_t'(ir[D_MSB:D_LSB]);
  endfunction

  // Immediate-load select (S=1) versus ALU operation (S=0)
  function automatic logic inst_is_imm(input logic [7:0] ir);
    return ir[S_BIT];
  endfunction

endpackage

// File: rtl/k2_alu.sv
// k2_alu: combinational add/subtract unit for the K2 core.
// Ports:
//   a, b            DATA_W-bit operands
//   sub             0 = a+b, 1 = a-b
//   y               DATA_W-bit result (modulo 2^DATA_W)
//   cout_or_borrow  carry-out for add, borrow (a<b unsigned) for sub
module k2_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y,
  output logic              cout_or_borrow
);

  logic [DATA_W:0] sum_s;

  // One extra bit holds carry-out on add; on subtract it goes high exactly
  // when the unsigned difference is negative, i.e. the borrow.
  always_comb begin
    if (sub) begin
      sum_s = {1'b0, a} - {1'b0, b};
    end else begin
      sum_s = {1'b0, a} + {1'b0, b};
    end
  end

  assign y              = sum_s[DATA_W-1:0];
  assign cout_or_borrow = sum_s[DATA_W];

endmodule

// File: rtl/k2_core.sv
// k2_core: K2 two-state fetch/execute engine.
// Fetches an 8-bit instruction from a combinational program ROM addressed by
// pc, then executes it on the next enabled cycle (2 cycles per instruction).
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (priority over en)
//   en        run enable; 0 freezes the FSM and all architectural state
//   pc        PC_W-bit ROM address
//   inst      8-bit instruction returned by the ROM in the same cycle
//   ro        output register Ro
//   ro_valid  one-cycle pulse following each EXEC that writes Ro
//   carry     current C flag
//   halted    (only with K2_HALT_EN) set by a taken jump to itself
// Optional feature macro: K2_HALT_EN
module k2_core
  import k2_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PC_W-1:0]   pc,
  input  logic [7:0]        inst,
  output logic [DATA_W-1:0] ro,
  output logic              ro_valid,
`ifdef K2_HALT_EN
  output logic              halted,
`endif
  output logic              carry
);

  state_t            state_r;
  logic [7:0]        ir_r;
  logic [PC_W-1:0]   pc_r;
  logic [DATA_W-1:0] ra_r;
  logic [DATA_W-1:0] rb_r;
  logic [DATA_W-1:0] ro_r;
  logic              c_r;
  logic              ro_valid_r;

  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   addr_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] alu_y_s;
  logic              alu_c_s;
  logic              taken_s;
  logic [PC_W-1:0]   pc_next_s;
  logic [DATA_W-1:0] ra_next_s;
  logic [DATA_W-1:0] rb_next_s;
  logic [DATA_W-1:0] ro_next_s;
  logic              c_next_s;
  logic              ro_wr_s;
  logic              run_s;

  assign pc_inc_s = pc_r + PC_W'(1);
  // Size casts cover both zero-extension and truncation of the 4-bit field
  assign addr_s   = PC_W'(ir_r[3:0]);
  assign imm_s    = DATA_W'(ir_r[2:0]);

  k2_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a              (ra_r),
    .b              (rb_r),
    .sub            (ir_r[SUB_BIT]),
    .y              (alu_y_s),
    .cout_or_borrow (alu_c_s)
  );

  // Execute-stage decode: next values of pc and registers for the held IR
  always_comb begin
    taken_s   = 1'b0;
    ra_next_s = ra_r;
    rb_next_s = rb_r;
    ro_next_s = ro_r;
    c_next_s  = c_r;
    ro_wr_s   = 1'b0;
    if (ir_r[J_BIT]) begin
      taken_s = 1'b1;
    end else if (ir_r[C_BIT]) begin
      taken_s = c_r;
    end else begin
      case (inst_dest(ir_r))
        DST_RA: begin
          if (inst_is_imm(ir_r)) begin
            ra_next_s = imm_s;
          end else begin
            ra_next_s = alu_y_s;
            c_next_s  = alu_c_s;
          end
        end
        DST_RB: begin
          if (inst_is_imm(ir_r)) begin
            rb_next_s = imm_s;
          end else begin
            rb_next_s = alu_y_s;
            c_next_s  = alu_c_s;
          end
        end
        DST_RO: begin
          ro_next_s = ra_r;
          ro_wr_s   = 1'b1;
        end
        DST_NONE: begin
          ro_wr_s = 1'b0;
        end
        default: begin
          ro_wr_s = 1'b0;
        end
      endcase
    end
    if (taken_s) begin
      pc_next_s = addr_s;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

`ifdef K2_HALT_EN
  logic halted_r;
  logic self_jump_s;

  // pc still holds the address of the executing instruction during EXEC
  assign self_jump_s = taken_s && (addr_s == pc_r);
  assign run_s       = en && !halted_r;
  assign halted      = halted_r;

  // Halt latch: set by an executed jump to itself, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (run_s && (state_r == ST_EXEC) && self_jump_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end
`else
  assign run_s = en;
`endif

  // FSM and architectural state; ro_valid is a pulse so it clears every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      ir_r       <= 8'h00;
      pc_r       <= '0;
      ra_r       <= '0;
      rb_r       <= '0;
      ro_r       <= '0;
      c_r        <= 1'b0;
      ro_valid_r <= 1'b0;
    end else begin
      ro_valid_r <= 1'b0;
      if (run_s) begin
        case (state_r)
          ST_FETCH: begin
            ir_r    <= inst;
            state_r <= ST_EXEC;
          end
          ST_EXEC: begin
            pc_r       <= pc_next_s;
            ra_r       <= ra_next_s;
            rb_r       <= rb_next_s;
            ro_r       <= ro_next_s;
            c_r        <= c_next_s;
            ro_valid_r <= ro_wr_s;
            state_r    <= ST_FETCH;
          end
          default: begin
            state_r <= ST_FETCH;
          end
        endcase
      end
    end
  end

  assign pc       = pc_r;
  assign ro       = ro_r;
  assign ro_valid = ro_valid_r;
  assign carry    = c_r;

endmodule

// File: tb/tb_k2_core.sv
// tb_k2_core: self-checking bench for k2_core with a bench-side program ROM.
// Expected Ro values are queued when a program is loaded and compared as
// ro_valid pulses arrive. Build with K2_HALT_EN to cover the halt feature.
module tb_k2_core;

  localparam int DATA_W = 4;
  localparam int PC_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PC_W-1:0]   pc;
  logic [7:0]        inst;
  logic [DATA_W-1:0] ro;
  logic              ro_valid;
  logic              carry;
`ifdef K2_HALT_EN
  logic              halted;
`endif

  logic [7:0] rom [16];
  assign inst = rom[pc];

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  k2_core #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pc       (pc),
    .inst     (inst),
    .ro       (ro),
    .ro_valid (ro_valid),
`ifdef K2_HALT_EN
    .halted   (halted),
`endif
    .carry    (carry)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each Ro write is compared against the next queued value
  always @(negedge clk) begin
    if (!rst && ro_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ro", int'(ro), -1);
      end else begin
        check("sb_ro", int'(ro), exp_q.pop_front());
      end
    end
  end

  // Advance n rising edges, then settle just past the falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_fib();
    fill_nop();
    rom[0] = 8'h08; rom[1] = 8'h19; rom[2] = 8'h20;
    rom[3] = 8'h10; rom[4] = 8'h70; rom[5] = 8'h00;
    rom[6] = 8'h14; rom[7] = 8'h04; rom[8] = 8'hB2;
  endtask

  task automatic push_fib();
    int seq [12];
    seq = '{0, 1, 1, 2, 3, 5, 8, 13, 0, 1, 1, 2};
    for (int i = 0; i < 12; i++) exp_q.push_back(seq[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PC_W-1:0]   pc_snap;
    logic [DATA_W-1:0] ro_snap;
    logic              c_snap;

    rst = 1'b1;
    en  = 1'b1;
    fill_nop();

    // Reset state and first instruction timing
    @(negedge clk);
    step(2);
    check("rst_pc", int'(pc), 0);
    check("rst_ro", int'(ro), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_ro_valid", int'(ro_valid), 0);
`ifdef K2_HALT_EN
    check("rst_halted", int'(halted), 0);
`endif
    rst = 1'b0;
    step(2);
    check("rst_pc_after_2", int'(pc), 1);

    // Immediate load then move: single pulse four cycles after release
    fill_nop();
    rom[0] = 8'h0D; rom[1] = 8'h20;
    exp_q.push_back(5);
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check("imm_ro_valid", int'(ro_valid), (c == 4) ? 1 : 0);
      if (c == 4) check("imm_ro", int'(ro), 5);
    end
    drain("imm", 10);

    // Add with and without carry, then taken JC
    fill_nop();
    rom[0] = 8'h0F; rom[1] = 8'h1F; rom[2] = 8'h00; rom[3] = 8'h20;
    rom[4] = 8'h00; rom[5] = 8'h20; rom[6] = 8'h7A;
    rom[10] = 8'h20; rom[11] = 8'hBB;
    exp_q.push_back(14); exp_q.push_back(5); exp_q.push_back(5);
    do_reset();
    step(8);
    check("add_ro14", int'(ro), 14);
    check("add_c0", int'(carry), 0);
    step(4);
    check("add_ro5", int'(ro), 5);
    check("add_c1", int'(carry), 1);
    step(2);
    check("jc_taken_pc", int'(pc), 10);
    drain("carry", 40);

    // Subtract with borrow wraps modulo 16
    fill_nop();
    rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'h04; rom[3] = 8'h20;
    exp_q.push_back(15);
    do_reset();
    step(8);
    check("sub_ro", int'(ro), 15);
    check("sub_borrow", int'(carry), 1);
    drain("sub", 10);

    // Fibonacci with overflow restart
    load_fib();
    push_fib();
    do_reset();
    drain("fib", 3000);

    // en gating during EXEC leaves everything frozen
    load_fib();
    push_fib();
    do_reset();
    step(21);
    en = 1'b0;
    pc_snap = pc;
    ro_snap = ro;
    c_snap  = carry;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("en_pc_hold", int'(pc), int'(pc_snap));
      check("en_ro_hold", int'(ro), int'(ro_snap));
      check("en_c_hold", int'(carry), int'(c_snap));
      check("en_ro_valid_low", int'(ro_valid), 0);
    end
    en = 1'b1;
    drain("en_fib", 3000);

    // pc wraps from 15 to 0
    fill_nop();
    do_reset();
    step(30);
    check("wrap_pc15", int'(pc), 15);
    step(2);
    check("wrap_pc0", int'(pc), 0);

    // Jump to self
    fill_nop();
    rom[3] = 8'hB3;
    do_reset();
    step(8);
    check("self_pc", int'(pc), 3);
`ifdef K2_HALT_EN
    check("halt_set", int'(halted), 1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("halt_pc_hold", int'(pc), 3);
      check("halt_hold", int'(halted), 1);
    end
    do_reset();
    check("halt_cleared", int'(halted), 0);
    check("halt_rst_pc", int'(pc), 0);
`else
    step(20);
    check("self_loop_pc", int'(pc), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
